ahb_lite_master: RTL and testbench

Single-channel AHB-Lite bus initiator that turns a simple core-side valid/ready request port into pipelined AHB transfers. It drives the SoC AHB bus that the on-chip BSRAM memory interface answers. It overlaps the address phase of the next request with the data phase of the current one. Each transfer returns exactly one in-order response.

---
 rtl/ahb_lite_master.sv | 175 +++++++++++++++++
 tb/tb_ahb_lite_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: pipelined single-channel AHB-Lite initiator.
// Turns a core valid/ready request port into NONSEQ SINGLE transfers.
//
// Ports:
//   HCLK, HRESETn          clock, async active-low reset
//   req_valid/req_ready    core request handshake
//   req_addr/write/size    request attributes (HSIZE encoding)
//   req_wdata/req_wstrb    write data and byte strobes
//   rsp_valid/rdata/err    one-cycle in-order response
//   H*                     AHB-Lite master bus signals
//
// Optional build macro: AHB_MASTER_ALIGN_CHECK_EN
//   Rejects misaligned / oversized requests locally with an
//   error response instead of issuing them on the bus.
module ahb_lite_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int WORD_WIDTH  = 32,
  parameter int HPROT_WIDTH = 4,
  parameter logic [HPROT_WIDTH-1:0] HPROT_VALUE = 4'b0011
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [2:0]              req_size,
  input  logic [WORD_WIDTH-1:0]   req_wdata,
  input  logic [WORD_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  output logic [WORD_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   HADDR,
  output logic [1:0]              HTRANS,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [2:0]              HBURST,
  output logic [HPROT_WIDTH-1:0]  HPROT,
  output logic                    HMASTLOCK,
  output logic [WORD_WIDTH-1:0]   HWDATA,
  output logic [WORD_WIDTH/8-1:0] HWSTRB,
  input  logic [WORD_WIDTH-1:0]   HRDATA,
  input  logic                    HREADY,
  input  logic                    HRESP
);

  localparam int SW = WORD_WIDTH / 8;
  localparam logic [2:0] MAXSZ = 3'($clog2(SW));

  typedef struct packed {
    logic                  v;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr;
    logic [2:0]            size;
    logic [WORD_WIDTH-1:0] wdata;
    logic [SW-1:0]         wstrb;
  } slot_t;

  slot_t                 ap_q, ap_d;
  logic                  dp_v_q, dp_v_d;
  logic                  dp_wr_q, dp_wr_d;
  logic                  nonseq_q, nonseq_d;
  logic [WORD_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [SW-1:0]         hwstrb_q, hwstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WORD_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic ap_done;
  logic dp_done;
  logic accept;
  logic illegal;

`ifdef AHB_MASTER_ALIGN_CHECK_EN
  logic [ADDR_WIDTH-1:0] amask;
  assign amask = (ADDR_WIDTH'(1) << req_size)
               - ADDR_WIDTH'(1);
  assign illegal = (req_size > MAXSZ)
                || (|(req_addr & amask));
`else
  assign illegal = 1'b0;
`endif

  // A cancelled AP (HTRANS forced IDLE) must not count as done.
  assign ap_done = ap_q.v && nonseq_q
                && HREADY && !HRESP;
  assign dp_done = dp_v_q && HREADY;

  // Illegal requests bypass the bus, so they wait for an empty pipe
  // to keep responses in order.
  always_comb begin
    req_ready = 1'b0;
    if (HRESETn) begin
      if (illegal)
        req_ready = !ap_q.v && !dp_v_q;
      else
        req_ready = !ap_q.v || ap_done;
    end
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    ap_d     = ap_q;
    dp_v_d   = dp_v_q;
    dp_wr_d  = dp_wr_q;
    hwdata_d = hwdata_q;
    hwstrb_d = hwstrb_q;
    if (ap_done) begin
      dp_v_d   = 1'b1;
      dp_wr_d  = ap_q.wr;
      hwdata_d = ap_q.wdata;
      hwstrb_d = ap_q.wstrb;
      ap_d.v   = 1'b0;
    end else if (dp_done) begin
      dp_v_d = 1'b0;
    end
    if (accept && !illegal) begin
      ap_d.v     = 1'b1;
      ap_d.addr  = req_addr;
      ap_d.wr    = req_write;
      ap_d.size  = req_size;
      ap_d.wdata = req_wdata;
      ap_d.wstrb = req_wstrb;
    end
    // First ERROR cycle: drop the pending address phase to IDLE.
    nonseq_d = ap_d.v;
    if (dp_v_q && HRESP && !HREADY)
      nonseq_d = 1'b0;
    rsp_valid_d = dp_done || (accept && illegal);
    rsp_err_d   = (dp_done && HRESP)
               || (accept && illegal);
    rsp_rdata_d = '0;
    if (dp_done && !dp_wr_q && !HRESP)
      rsp_rdata_d = HRDATA;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_q        <= '0;
      dp_v_q      <= 1'b0;
      dp_wr_q     <= 1'b0;
      nonseq_q    <= 1'b0;
      hwdata_q    <= '0;
      hwstrb_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ap_q        <= ap_d;
      dp_v_q      <= dp_v_d;
      dp_wr_q     <= dp_wr_d;
      nonseq_q    <= nonseq_d;
      hwdata_q    <= hwdata_d;
      hwstrb_q    <= hwstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign HADDR     = ap_q.addr;
  assign HWRITE    = ap_q.wr;
  assign HSIZE     = ap_q.size;
  assign HTRANS    = {nonseq_q, 1'b0};
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VALUE;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;
  assign HWSTRB    = hwstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed bench for ahb_lite_master.
// Slave side is driven by hand cycle by cycle.
module tb_ahb_lite_master;

  logic        HCLK;
  logic        HRESETn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [3:0]  HWSTRB;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int n_chk;
  int n_fail;
  logic seen;

  ahb_lite_master dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HMASTLOCK (HMASTLOCK),
    .HWDATA    (HWDATA),
    .HWSTRB    (HWSTRB),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge HCLK);
    #1;
  endtask

  task automatic send(input logic [31:0] a,
                      input logic w,
                      input logic [31:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_size  = 3'd2;
    req_wdata = d;
    req_wstrb = 4'hF;
  endtask

  task automatic idle;
    req_valid = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    HRESETn = 1'b0;
    HRDATA  = '0;
    HREADY  = 1'b1;
    HRESP   = 1'b0;
    send(32'h0, 1'b1, 32'h9);
    step;
    step;
    check("rst_htrans", 32'(HTRANS), 0);
    check("rst_haddr", HADDR, 0);
    check("rst_hwrite", 32'(HWRITE), 0);
    check("rst_hsize", 32'(HSIZE), 0);
    check("rst_hwdata", HWDATA, 0);
    check("rst_hwstrb", 32'(HWSTRB), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("hburst", 32'(HBURST), 0);
    check("hprot", 32'(HPROT), 32'h3);
    check("hmastlock", 32'(HMASTLOCK), 0);
    idle;
    @(negedge HCLK);
    HRESETn = 1'b1;
    step;

    // single zero-wait read
    send(32'h100, 1'b0, 32'h0);
    check("t1_ready", 32'(req_ready), 1);
    step;
    idle;
    check("t1_htrans", 32'(HTRANS), 2);
    check("t1_haddr", HADDR, 32'h100);
    check("t1_hwrite", 32'(HWRITE), 0);
    check("t1_hsize", 32'(HSIZE), 2);
    HRDATA = 32'hDEADBEEF;
    step;
    check("t1_htrans_idle", 32'(HTRANS), 0);
    check("t1_rsp_early", 32'(rsp_valid), 0);
    step;
    HRDATA = 32'h0;
    check("t1_rsp_valid", 32'(rsp_valid), 1);
    check("t1_rdata", rsp_rdata, 32'hDEADBEEF);
    check("t1_err", 32'(rsp_err), 0);
    step;
    check("t1_rsp_pulse", 32'(rsp_valid), 0);

    // four back-to-back writes
    for (int i = 0; i < 4; i++) begin
      send(32'(4 * i), 1'b1, 32'(i + 1));
      step;
      check("t2_htrans", 32'(HTRANS), 2);
      check("t2_haddr", HADDR, 32'(4 * i));
      check("t2_hwrite", 32'(HWRITE), 1);
      if (i > 0)
        check("t2_hwdata", HWDATA, 32'(i));
      check("t2_rsp", 32'(rsp_valid),
            (i >= 2) ? 32'd1 : 32'd0);
    end
    idle;
    step;
    check("t2_htrans_idle", 32'(HTRANS), 0);
    check("t2_hwdata4", HWDATA, 32'd4);
    check("t2_hwstrb", 32'(HWSTRB), 32'hF);
    check("t2_rsp3", 32'(rsp_valid), 1);
    step;
    check("t2_rsp4", 32'(rsp_valid), 1);
    check("t2_err", 32'(rsp_err), 0);
    check("t2_rdata", rsp_rdata, 0);
    step;
    check("t2_rsp_end", 32'(rsp_valid), 0);

    // read with two wait states, second read queued in AP
    send(32'h200, 1'b0, 32'h0);
    step;
    check("t3_haddr0", HADDR, 32'h200);
    send(32'h204, 1'b0, 32'h0);
    step;
    idle;
    check("t3_haddr1", HADDR, 32'h204);
    check("t3_htrans1", 32'(HTRANS), 2);
    HREADY = 1'b0;
    #1;
    check("t3_ready_wait", 32'(req_ready), 0);
    step;
    check("t3_haddr_w1", HADDR, 32'h204);
    check("t3_htrans_w1", 32'(HTRANS), 2);
    check("t3_rsp_w1", 32'(rsp_valid), 0);
    step;
    check("t3_haddr_w2", HADDR, 32'h204);
    check("t3_htrans_w2", 32'(HTRANS), 2);
    check("t3_rsp_w2", 32'(rsp_valid), 0);
    HREADY = 1'b1;
    HRDATA = 32'h12345678;
    step;
    check("t3_rsp_a", 32'(rsp_valid), 1);
    check("t3_rdata_a", rsp_rdata, 32'h12345678);
    check("t3_htrans_idle", 32'(HTRANS), 0);
    HRDATA = 32'hCAFEF00D;
    step;
    check("t3_rsp_b", 32'(rsp_valid), 1);
    check("t3_rdata_b", rsp_rdata, 32'hCAFEF00D);
    HRDATA = 32'h0;
    step;
    check("t3_rsp_end", 32'(rsp_valid), 0);

    // ERROR on a write with a read pending in AP
    send(32'h40, 1'b1, 32'h55);
    step;
    check("t4_haddr_w", HADDR, 32'h40);
    send(32'h44, 1'b0, 32'h0);
    step;
    idle;
    check("t4_haddr_r", HADDR, 32'h44);
    check("t4_hwdata", HWDATA, 32'h55);
    HREADY = 1'b0;
    HRESP  = 1'b1;
    #1;
    check("t4_ready_e1", 32'(req_ready), 0);
    step;
    check("t4_htrans_idle", 32'(HTRANS), 0);
    check("t4_haddr_hold", HADDR, 32'h44);
    check("t4_rsp_e1", 32'(rsp_valid), 0);
    HREADY = 1'b1;
    #1;
    check("t4_ready_e2", 32'(req_ready), 0);
    step;
    HRESP = 1'b0;
    check("t4_rsp_err_v", 32'(rsp_valid), 1);
    check("t4_rsp_err", 32'(rsp_err), 1);
    check("t4_rsp_rdata0", rsp_rdata, 0);
    check("t4_reissue", 32'(HTRANS), 2);
    check("t4_reissue_a", HADDR, 32'h44);
    check("t4_reissue_w", 32'(HWRITE), 0);
    step;
    check("t4_htrans_done", 32'(HTRANS), 0);
    check("t4_rsp_gap", 32'(rsp_valid), 0);
    HRDATA = 32'hA5A5A5A5;
    step;
    HRDATA = 32'h0;
    check("t4_rsp_r", 32'(rsp_valid), 1);
    check("t4_rsp_r_err", 32'(rsp_err), 0);
    check("t4_rsp_r_data", rsp_rdata, 32'hA5A5A5A5);
    step;

    // reset during a stalled data phase
    send(32'h300, 1'b1, 32'h77);
    step;
    idle;
    step;
    check("t5_hwdata", HWDATA, 32'h77);
    HREADY = 1'b0;
    #2;
    HRESETn = 1'b0;
    #1;
    check("t5_htrans", 32'(HTRANS), 0);
    check("t5_haddr", HADDR, 0);
    check("t5_hwrite", 32'(HWRITE), 0);
    check("t5_hwdata0", HWDATA, 0);
    check("t5_hwstrb0", 32'(HWSTRB), 0);
    check("t5_rsp", 32'(rsp_valid), 0);
    check("t5_ready", 32'(req_ready), 0);
    #1;
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      step;
      if (rsp_valid)
        seen = 1'b1;
    end
    check("t5_no_rsp", 32'(seen), 0);

    // misaligned word access
    send(32'h102, 1'b0, 32'h0);
    check("t6_ready", 32'(req_ready), 1);
    step;
    idle;
`ifdef AHB_MASTER_ALIGN_CHECK_EN
    check("t6_htrans", 32'(HTRANS), 0);
    check("t6_rsp", 32'(rsp_valid), 1);
    check("t6_err", 32'(rsp_err), 1);
    check("t6_rdata", rsp_rdata, 0);
    step;
    check("t6_htrans2", 32'(HTRANS), 0);
    check("t6_rsp_end", 32'(rsp_valid), 0);
`else
    check("t6_htrans", 32'(HTRANS), 2);
    check("t6_haddr", HADDR, 32'h102);
    step;
    step;
    check("t6_rsp", 32'(rsp_valid), 1);
    check("t6_err", 32'(rsp_err), 0);
`endif
    step;
    step;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
